// File: rtl/obi_addr_demux_if.sv
// obi_addr_demux_if: manager-side and target-side OBI signals of one address demultiplexer
interface obi_addr_demux_if #(
  parameter int NUM_TARGETS = 3
);
  logic                      req_i;
  logic                      gnt_o;
  logic [31:0]               addr_i;
  logic                      we_i;
  logic [3:0]                be_i;
  logic [31:0]               wdata_i;
  logic                      rvalid_o;
  logic [31:0]               rdata_o;
  logic                      err_o;
  logic [NUM_TARGETS-1:0]    tgt_req_o;
  logic [NUM_TARGETS-1:0]    tgt_gnt_i;
  logic [31:0]               tgt_addr_o;
  logic                      tgt_we_o;
  logic [3:0]                tgt_be_o;
  logic [31:0]               tgt_wdata_o;
  logic [NUM_TARGETS-1:0]    tgt_rvalid_i;
  logic [32*NUM_TARGETS-1:0] tgt_rdata_i;
  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, tgt_gnt_i, tgt_rvalid_i, tgt_rdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o, tgt_req_o, tgt_addr_o, tgt_we_o, tgt_be_o, tgt_wdata_o
  );
  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, tgt_gnt_i, tgt_rvalid_i, tgt_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, tgt_req_o, tgt_addr_o, tgt_we_o, tgt_be_o, tgt_wdata_o
  );
endinterface

// File: rtl/obi_addr_demux.sv
// obi_addr_demux: routes one OBI manager to NUM_TARGETS targets by base/mask decode, in-order responses
module obi_addr_demux #(
  parameter int                        NUM_TARGETS     = 3,
  parameter int                        MAX_OUTSTANDING = 2,
  parameter logic [32*NUM_TARGETS-1:0] BASE_ADDR       = {32'h0010_0000, 32'h0008_0000, 32'h0000_0000},
  parameter logic [32*NUM_TARGETS-1:0] ADDR_MASK       = {3{32'hFFFF_0000}},
  parameter logic [31:0]               ERR_RDATA       = 32'hBADC_AB1E
) (
  input  logic              clk_i,
  input  logic              rst_i,
  obi_addr_demux_if.slave   bus
);
  localparam int SW = $clog2(NUM_TARGETS + 1);
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [SW-1:0] ERR_IDX = SW'(NUM_TARGETS);

  logic [SW-1:0]        r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_cnt;
  logic [SW-1:0]        r_last;
  logic [SW-1:0]        w_sel, w_head;
  logic                 w_allow, w_push, w_pop;
  logic [NUM_TARGETS:0] w_gnt_ext, w_rv_ext;
  logic [31:0]          w_rd [NUM_TARGETS+1];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction

  // address decode: the lowest matching target wins, no match selects the error target
  always_comb begin
    w_sel = ERR_IDX;
    for (int k = NUM_TARGETS - 1; k >= 0; k--)
      if ((bus.addr_i & ADDR_MASK[32*k +: 32]) == (BASE_ADDR[32*k +: 32] & ADDR_MASK[32*k +: 32])) w_sel = SW'(k);
  end

  // response data per index, with the error target as the extra last entry
  always_comb begin
    for (int k = 0; k < NUM_TARGETS; k++) w_rd[k] = bus.tgt_rdata_i[32*k +: 32];
    w_rd[NUM_TARGETS] = ERR_RDATA;
  end

  // the error target always grants and always responds, hence the constant top bits
  assign w_gnt_ext = {1'b1, bus.tgt_gnt_i};
  assign w_rv_ext  = {1'b1, bus.tgt_rvalid_i};
  assign w_head    = r_fifo[r_rptr];
  // switching targets only with nothing outstanding keeps responses in order
  assign w_allow   = !rst_i && bus.req_i && r_cnt < CW'(MAX_OUTSTANDING) && (r_cnt == '0 || w_sel == r_last);
  assign w_push    = w_allow && w_gnt_ext[w_sel];
  assign w_pop     = !rst_i && r_cnt != '0 && w_rv_ext[w_head];

  assign bus.gnt_o       = w_push;
  assign bus.tgt_req_o   = (w_allow && w_sel != ERR_IDX) ? NUM_TARGETS'(1) << w_sel : '0;
  assign bus.rvalid_o    = w_pop;
  assign bus.err_o       = w_pop && w_head == ERR_IDX;
  assign bus.rdata_o     = (rst_i || r_cnt == '0) ? '0 : w_rd[w_head];
  assign bus.tgt_addr_o  = bus.addr_i;
  assign bus.tgt_we_o    = bus.we_i;
  assign bus.tgt_be_o    = bus.be_i;
  assign bus.tgt_wdata_o = bus.wdata_i;

  // outstanding bookkeeping: pointers, occupancy and the most recently granted index
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_last <= '0;
    end else begin
      if (w_push) r_wptr <= nxt(r_wptr);
      if (w_push) r_last <= w_sel;
      if (w_pop) r_rptr <= nxt(r_rptr);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // storage of the selected index of each granted transaction
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wptr] <= w_sel;
  end
endmodule

// File: tb/tb_obi_addr_demux.sv
// tb_obi_addr_demux: directed and randomized checks of obi_addr_demux against a queue-based reference model
module tb_obi_addr_demux;
  localparam int NT = 3;
  localparam int MO = 2;
  localparam logic [31:0] ERR = 32'hBADC_AB1E;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last = 0;
  int   oq[$];
  rsp_t tq[NT][$];
  int   lat[NT] = '{1, 2, 1};
  logic [31:0] base[NT] = '{32'h0000_0000, 32'h0008_0000, 32'h0010_0000};
  logic [31:0] mask[NT] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  obi_addr_demux_if #(.NUM_TARGETS(NT)) bus();
  obi_addr_demux dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < NT; k++) if ((a & mask[k]) == (base[k] & mask[k])) return k;
    return NT;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000 | ($urandom & 32'hFFFC);
      1: return 32'h0008_0000 | ($urandom & 32'hFFFC);
      2: return 32'h0010_0000 | ($urandom & 32'hFFFC);
      3: return 32'h4000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic step(input bit rq, input logic [31:0] a, input bit w, input logic [3:0] b,
                      input logic [31:0] wd, input logic [NT-1:0] g, input bit spur, output bit granted);
    int sel, head;
    bit allow, egnt, erv, due;
    logic [NT-1:0] ereq;
    logic [31:0] erd;
    @(negedge clk);
    bus.req_i = rq; bus.addr_i = a; bus.we_i = w; bus.be_i = b; bus.wdata_i = wd; bus.tgt_gnt_i = g;
    for (int k = 0; k < NT; k++) begin
      due = tq[k].size() > 0 && tq[k][0].due <= cyc;
      bus.tgt_rvalid_i[k] = due || (spur && tq[k].size() == 0);
      bus.tgt_rdata_i[32*k +: 32] = due ? tq[k][0].data : $urandom;
    end
    #1;
    sel   = decode(a);
    allow = rq && oq.size() < MO && (oq.size() == 0 || sel == last);
    egnt  = allow && (sel == NT || g[sel]);
    ereq  = (allow && sel < NT) ? NT'(1) << sel : '0;
    head  = oq.size() > 0 ? oq[0] : -1;
    erv   = head == NT || (head >= 0 && tq[head].size() > 0 && tq[head][0].due <= cyc);
    erd   = head < 0 ? 32'h0 : head == NT ? ERR : (erv ? tq[head][0].data : 32'h0);
    check("gnt", 32'(bus.gnt_o), 32'(egnt));
    check("tgt_req", 32'(bus.tgt_req_o), 32'(ereq));
    check("rvalid", 32'(bus.rvalid_o), 32'(erv));
    check("err", 32'(bus.err_o), 32'(head == NT));
    if (head < 0 || erv) check("rdata", bus.rdata_o, erd);
    if (rq) begin
      check("tgt_addr", bus.tgt_addr_o, a);
      check("tgt_we", 32'(bus.tgt_we_o), 32'(w));
      check("tgt_be", 32'(bus.tgt_be_o), 32'(b));
      check("tgt_wdata", bus.tgt_wdata_o, wd);
    end
    @(posedge clk);
    if (erv) begin
      if (head < NT) void'(tq[head].pop_front());
      void'(oq.pop_front());
    end
    if (egnt) begin
      rsp_t r;
      oq.push_back(sel);
      last = sel;
      r.due = cyc + lat[sel % NT];
      r.data = $urandom;
      if (sel < NT) tq[sel].push_back(r);
    end
    cyc++;
    granted = egnt;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_i = 1'b1; bus.addr_i = 32'h0008_0000; bus.tgt_gnt_i = '1; bus.tgt_rvalid_i = '1;
    #1;
    check("rst_gnt", 32'(bus.gnt_o), 32'h0);
    check("rst_tgt_req", 32'(bus.tgt_req_o), 32'h0);
    check("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
    check("rst_err", 32'(bus.err_o), 32'h0);
    check("rst_rdata", bus.rdata_o, 32'h0);
    oq.delete();
    for (int k = 0; k < NT; k++) tq[k].delete();
    last = 0;
    bus.req_i = 1'b0; bus.tgt_rvalid_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic hold(input logic [31:0] a);
    bit g = 1'b0;
    for (int i = 0; i < 20 && !g; i++) step(1, a, 0, 4'hF, 32'h0, '1, 0, g);
    check("hold_granted", 32'(g), 32'h1);
  endtask

  initial begin
    bit g, rq, w, pend;
    logic [31:0] a, wd;
    logic [3:0] b;
    bus.req_i = 0; bus.addr_i = 0; bus.we_i = 0; bus.be_i = 0; bus.wdata_i = 0;
    bus.tgt_gnt_i = 0; bus.tgt_rvalid_i = 0; bus.tgt_rdata_i = 0;
    apply_reset();
    step(1, 32'h0000_0010, 0, 4'hF, 32'h0, '1, 0, g);
    step(0, 32'h0, 0, 4'h0, 32'h0, '1, 0, g);
    step(1, 32'h0008_0000, 0, 4'hF, 32'h0, '1, 0, g);
    step(1, 32'h0008_0004, 0, 4'hF, 32'h0, '1, 0, g);
    hold(32'h0008_0008);
    repeat (3) step(0, 32'h0, 0, 4'h0, 32'h0, '1, 0, g);
    step(1, 32'h0008_0000, 0, 4'hF, 32'h0, '1, 0, g);
    hold(32'h0010_0000);
    repeat (2) step(0, 32'h0, 0, 4'h0, 32'h0, '1, 0, g);
    step(1, 32'h4000_0000, 0, 4'hF, 32'h0, '1, 0, g);
    step(1, 32'h4000_0004, 0, 4'hF, 32'h0, '1, 0, g);
    repeat (2) step(0, 32'h0, 0, 4'h0, 32'h0, '1, 0, g);
    step(1, 32'h0010_0020, 1, 4'b0011, 32'hCAFE_F00D, '1, 0, g);
    repeat (2) step(0, 32'h0, 0, 4'h0, 32'h0, '1, 0, g);
    step(1, 32'h0008_0000, 0, 4'hF, 32'h0, '1, 0, g);
    step(1, 32'h0008_0004, 0, 4'hF, 32'h0, '1, 0, g);
    apply_reset();
    repeat (3) step(0, 32'h0, 0, 4'h0, 32'h0, '1, 1, g);
    step(1, 32'h0000_0020, 0, 4'hF, 32'h0, '1, 0, g);
    step(0, 32'h0, 0, 4'h0, 32'h0, '1, 1, g);
    pend = 1'b0;
    rq = 1'b0; a = 0; w = 0; b = 0; wd = 0;
    repeat (4000) begin
      if (!pend) begin
        rq = $urandom_range(0, 9) < 7;
        a  = rand_addr();
        w  = 1'($urandom);
        b  = 4'($urandom);
        wd = $urandom;
      end
      step(rq, a, w, b, wd, NT'($urandom), $urandom_range(0, 4) == 0, g);
      pend = rq && !g;
      if ($urandom_range(0, 499) == 0) begin
        apply_reset();
        pend = 1'b0;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
